gray_frame_sequencer: RTL

//  Frame-level controller for the RGB444->grayscale converter.
//  - On i_start, reads one IMG_W x IMG_H frame of RGB444 pixels from a synchronous-read frame buffer, in raster order.
//  - Drives each pixel into the converter and captures the converter result (fixed 1-cycle latency, no backpressure).
//  - Re-emits the result as a valid/ready stream, tagged with frame/line markers, to the Gaussian/Sobel window stage.
//  - Absorbs downstream stalls with a credit-checked output FIFO, so the converter never loses a pixel.

---
 rtl/gray_frame_sequencer_if.sv | 12 +
 rtl/gray_frame_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gray_frame_sequencer_if.sv
// Tagged grayscale pixel stream toward the window stage; a beat moves when valid & ready.
interface gray_frame_sequencer_if;
  logic        valid;
  logic        ready;
  logic [11:0] data;
  logic        sof;
  logic        eol;
  logic        eof;

  modport master (output valid, data, sof, eol, eof, input ready);
  modport slave  (input valid, data, sof, eol, eof, output ready);
endinterface

// File: rtl/gray_frame_sequencer.sv
// Raster-reads one frame, feeds the grayscale converter and streams tagged results; start to first valid is 4 cycles.
// Reads are credit-gated against FIFO occupancy plus in-flight pixels, so downstream stalls never drop a converter result.
module gray_frame_sequencer #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_W-1:0]     o_rd_addr,
  input  logic [11:0]           i_rd_data,
  output logic                  o_cvt_valid,
  output logic [11:0]           o_cvt_data,
  input  logic                  i_cvt_valid,
  input  logic [11:0]           i_cvt_data,
  gray_frame_sequencer_if.master stream
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              last_pix;
  logic              credit_ok;
  logic              drain_done;
  logic              stg1_vld, stg2_vld;
  logic [2:0]        stg1_tag, stg2_tag;   // {sof, eol, eof} travelling beside the pixel
  logic [CW:0]       used;

  logic [14:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              push, pop, wr, rd;
  logic [14:0]       head;

  assign last_pix  = (x == X_LAST) && (y == Y_LAST);
  assign used      = {1'b0, fifo_cnt} + {{CW{1'b0}}, stg1_vld} + {{CW{1'b0}}, stg2_vld};
  assign credit_ok = (used < (CW+1)'(FIFO_DEPTH));
  // Frame is finished when nothing is in flight and the last buffered pixel leaves this cycle.
  assign drain_done = !stg1_vld && !stg2_vld &&
                      (fifo_empty || ((fifo_cnt == CW'(1)) && pop));

  always_comb begin
    state_nxt = state;
    o_rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = RUN;
      end
      RUN: begin
        o_rd_en = credit_ok;
        if (credit_ok && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_busy <= (state_nxt != IDLE);
      o_done <= (state == DRAIN) && (state_nxt == IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      stg1_vld <= 1'b0;
      stg2_vld <= 1'b0;
      stg1_tag <= '0;
      stg2_tag <= '0;
    end else begin
      stg1_vld <= o_rd_en;
      stg2_vld <= stg1_vld;
      stg2_tag <= stg1_tag;
      if (o_rd_en)
        stg1_tag <= {(x == '0) && (y == '0), x == X_LAST, last_pix};
      if (state == IDLE && i_start) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (o_rd_en) begin
        addr <= addr + 1'b1;
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign o_rd_addr   = addr;
  assign o_cvt_valid = stg1_vld;
  assign o_cvt_data  = stg1_vld ? i_rd_data : '0;

  // Converter results are accepted only when a read we issued is due at stage 2.
  assign push       = stg2_vld && i_cvt_valid;
  assign pop        = stream.valid && stream.ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign rd         = pop && !fifo_empty;
  assign wr         = push && (!fifo_full || rd);
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr) fifo_mem[wr_ptr] <= {stg2_tag, i_cvt_data};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (rd && !wr)
        fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  assign stream.valid = !fifo_empty;
  assign stream.data  = fifo_empty ? '0 : head[11:0];
  assign stream.sof   = !fifo_empty && head[14];
  assign stream.eol   = !fifo_empty && head[13];
  assign stream.eof   = !fifo_empty && head[12];

  assert property (@(posedge CLK) disable iff (!RST) !(push && fifo_full && !pop));
endmodule
